// File: rtl/pipe_add_sub.sv
// Pipelined adder/subtractor: one CHUNK-bit carry slice per stage, skewed operands
// travel forward with the partial result; a single global stall freezes every stage.
module pipe_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  input  logic [1:0]       op,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             zero,
  output logic             result_sign,
  output logic             overflow
);
  localparam int STAGES = WIDTH / CHUNK;

  // Index 0 is the capture register; index k+1 holds the state after slice k.
  logic [WIDTH-1:0] r_a   [0:STAGES-1];
  logic [WIDTH-1:0] r_b   [0:STAGES-1];
  logic [WIDTH-1:0] r_res [0:STAGES];
  logic             r_c   [0:STAGES];
  logic             r_z   [0:STAGES];
  logic             r_v   [0:STAGES];
  logic             r_ovf;

  logic [CHUNK:0]   w_sum      [0:STAGES-1];
  logic [WIDTH-1:0] w_res_next [0:STAGES-1];
  logic [WIDTH-1:0] w_beff;
  logic             w_ci;
  logic             w_adv;
  logic             w_cmsb;

  assign w_adv  = !r_v[STAGES] || out_ready;
  assign w_beff = op[0] ? ~data_B : data_B;
  assign w_ci   = op[1] ? carry_in : op[0];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      assign w_sum[gi] = {1'b0, r_a[gi][gi*CHUNK +: CHUNK]}
                       + {1'b0, r_b[gi][gi*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, r_c[gi]};
      // Upper result slices are still zero here, so OR-ing the new slice in is enough.
      assign w_res_next[gi] = r_res[gi] | (WIDTH'(w_sum[gi][CHUNK-1:0]) << (gi*CHUNK));
    end
  endgenerate

  // Carry into the MSB recovered from the MSB's own sum bit.
  assign w_cmsb = r_a[STAGES-1][WIDTH-1] ^ r_b[STAGES-1][WIDTH-1] ^ w_sum[STAGES-1][CHUNK-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        r_res[k] <= '0;
        r_c[k]   <= 1'b0;
        r_z[k]   <= 1'b0;
        r_v[k]   <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_v[0]   <= in_valid;
      r_a[0]   <= data_A;
      r_b[0]   <= w_beff;
      r_c[0]   <= w_ci;
      r_z[0]   <= 1'b1;
      r_res[0] <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        r_v[k]   <= r_v[k-1];
        r_res[k] <= w_res_next[k-1];
        r_c[k]   <= w_sum[k-1][CHUNK];
        r_z[k]   <= r_z[k-1] & (w_sum[k-1][CHUNK-1:0] == '0);
      end
      for (int k = 1; k < STAGES; k++) begin
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
      r_ovf <= w_cmsb ^ w_sum[STAGES-1][CHUNK];
    end
  end

  assign in_ready    = w_adv;
  assign out_valid   = r_v[STAGES];
  assign result      = r_res[STAGES];
  assign co          = r_c[STAGES];
  assign zero        = r_z[STAGES];
  assign result_sign = r_res[STAGES][WIDTH-1];
  assign overflow    = r_ovf;
endmodule

// File: tb/tb_pipe_add_sub.sv
// Scoreboard bench for pipe_add_sub (WIDTH=32, CHUNK=8): transfers push expected
// responses, a monitor pops and compares on every accepted output.
module tb_pipe_add_sub;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_A = '0;
  logic [31:0] data_B = '0;
  logic [1:0]  op = '0;
  logic        carry_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        co, zero, result_sign, overflow;

  pipe_add_sub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_A(data_A), .data_B(data_B), .op(op), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .co(co), .zero(zero), .result_sign(result_sign), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        zero;
    logic        sign;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  // Directed expectations written straight from the worked examples.
  logic        dir_en  = 1'b0;
  exp_t        dir_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci);
    exp_t    e;
    longint  ua, ub, uc, usum;
    longint  sa, sb_v, ssum;
    logic [31:0] be;
    be   = o[0] ? ~b : b;
    uc   = (o == 2'b00) ? 0 : (o == 2'b01) ? 1 : longint'(ci);
    ua   = longint'(a);
    ub   = longint'(be);
    usum = ua + ub + uc;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(be));
    ssum = sa + sb_v + uc;
    e.res  = usum[31:0];
    e.co   = (usum >= 64'sh1_0000_0000);
    e.zero = (usum[31:0] == 32'h0);
    e.sign = usum[31];
    e.ovf  = (ssum > 64'sh7FFF_FFFF) || (ssum < -64'sh8000_0000);
    return e;
  endfunction

  // Transfer recorder.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      if (dir_en) sb.push_back(dir_exp);
      else        sb.push_back(model(op, data_A, data_B, carry_in));
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(result), 64'hDEAD_0000_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_flags", 64'({result, co, zero, result_sign, overflow}), 64'(e));
        $display("out res=%h co=%b z=%b s=%b ov=%b", result, co, zero, result_sign, overflow);
      end
    end
  end

  // Present one operation and keep it until it is accepted (called just after a posedge).
  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic ci);
    logic acc;
    int   n;
    op = o; data_A = a; data_B = b; carry_in = ci; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'(n), 64'(0));
  endtask

  task automatic send_dir(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic [31:0] r, input logic c,
                          input logic s, input logic v);
    dir_en  = 1'b1;
    dir_exp = '{res: r, co: c, zero: (r == 32'h0), sign: s, ovf: v};
    send(o, a, b, ci);
    dir_en  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) check(name, 64'(out_valid), 64'(1));
  endtask

  logic pat [0:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic ov_seen [0:15];
  logic rnd_done = 1'b0;

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({out_valid, result, co, zero, result_sign, overflow}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Worked examples.
    send_dir(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send_dir(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    send_dir(2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    send_dir(2'b01, 32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    send_dir(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    send_dir(2'b10, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send_dir(2'b11, 32'd10,        32'd3,         1'b0, 32'd6,         1'b1, 1'b0, 1'b0);
    idle(8);

    // Bubble pattern at full throughput: transfer at the edge after each set-up,
    // so out_valid follows 4 edges later, i.e. 5 iterations after the set-up.
    for (int t = 0; t < 16; t++) begin
      in_valid = (t < 7) ? pat[t] : 1'b0;
      op = 2'($urandom_range(0, 3)); data_A = $urandom; data_B = $urandom; carry_in = 1'($urandom);
      @(negedge clk);
      ov_seen[t] = out_valid;
      @(posedge clk); #1;
    end
    for (int t = 0; t < 16; t++) begin
      check($sformatf("bubble_t%0d", t), 64'(ov_seen[t]),
            64'((t >= 5 && t < 12) ? pat[t-5] : 1'b0));
    end
    idle(4);

    // Back-pressure: 10 back-to-back ops with a 5-cycle output hold.
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        logic [31:0] held;
        wait_out_valid("bp_wait_valid");
        @(posedge clk); #1;
        out_ready = 1'b0;
        held = '0;
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          check("bp_in_ready_low", 64'(in_ready), 64'(0));
          if (h == 0) held = result;
          else check("bp_result_frozen", 64'(result), 64'(held));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(10);

    // Random traffic with random back-pressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(10);

    // Reset mid-stream: three ops in flight, the first stuck at the output.
    out_ready = 1'b0;
    send(2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0);
    send(2'b01, 32'h3333_3333, 32'h0000_0001, 1'b0);
    send(2'b10, 32'h5555_5555, 32'h0000_0004, 1'b1);
    in_valid = 1'b0;
    wait_out_valid("rst_wait_valid");
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    check("rst_mid_outputs", 64'({out_valid, result, co, zero, result_sign, overflow}), 64'(0));
    sb.delete();
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(8);
    send(2'b00, 32'h0000_0010, 32'h0000_0020, 1'b0);
    idle(8);

    // Drain.
    for (int n = 0; n < 50 && sb.size() != 0; n++) begin @(posedge clk); #1; end
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
